// File: rtl/compute_mem_engine.sv
// Command-driven memory engine: read, write and two-operand ALU ops
// executed against an on-chip word array, one command in flight at a time.
module compute_mem_engine #(
  parameter int MEM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int SAT_EN     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd,
  input  logic [ADDR_WIDTH-1:0] addA,
  input  logic [ADDR_WIDTH-1:0] addB,
  input  logic [ADDR_WIDTH-1:0] addC,
  input  logic [MEM_WIDTH-1:0]  DQ_i,
  output logic [MEM_WIDTH-1:0]  DQ_o,
  output logic                  rsp_valid,
  output logic                  ovf,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] CMD_RD  = 3'd0;
  localparam logic [2:0] CMD_WR  = 3'd1;
  localparam logic [2:0] CMD_ADD = 3'd2;
  localparam logic [2:0] CMD_SUB = 3'd3;
  localparam logic [2:0] CMD_AND = 3'd4;
  localparam logic [2:0] CMD_OR  = 3'd5;
  localparam logic [2:0] CMD_XOR = 3'd6;
  localparam logic [2:0] CMD_RSV = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FETCH_A,
    S_FETCH_B,
    S_EXEC,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [ADDR_WIDTH-1:0] b_q, b_d;
  logic [ADDR_WIDTH-1:0] c_q, c_d;
  logic [MEM_WIDTH-1:0]  op_a_q, op_a_d;
  logic [MEM_WIDTH-1:0]  op_b_q, op_b_d;
  logic [MEM_WIDTH-1:0]  dq_q, dq_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;

  logic [MEM_WIDTH-1:0]  mem_q [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [MEM_WIDTH-1:0]  mem_wdata;

  logic [MEM_WIDTH:0]    sum;
  logic [MEM_WIDTH-1:0]  diff;
  logic                  borrow;
  logic [MEM_WIDTH-1:0]  alu_res;
  logic                  alu_ovf;
  logic                  accept;

  assign cmd_ready = (state_q == S_IDLE) && rst;
  assign rsp_valid = (state_q == S_RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign DQ_o      = dq_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  always_comb begin
    sum     = {1'b0, op_a_q} + {1'b0, op_b_q};
    diff    = op_a_q - op_b_q;
    borrow  = op_a_q < op_b_q;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (cmd_q)
      CMD_ADD: begin
        alu_ovf = sum[MEM_WIDTH];
        alu_res = sum[MEM_WIDTH-1:0];
        if (SAT_EN != 0 && alu_ovf) alu_res = '1;
      end
      CMD_SUB: begin
        alu_ovf = borrow;
        alu_res = diff;
        if (SAT_EN != 0 && borrow) alu_res = '0;
      end
      CMD_AND: alu_res = op_a_q & op_b_q;
      CMD_OR:  alu_res = op_a_q | op_b_q;
      CMD_XOR: alu_res = op_a_q ^ op_b_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    dq_d      = dq_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = c_q;
    mem_wdata = alu_res;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d = cmd;
          a_d   = addA;
          b_d   = addB;
          c_d   = addC;
          case (cmd)
            CMD_RD: state_d = S_READ;
            CMD_WR: begin
              mem_we    = 1'b1;
              mem_waddr = addC;
              mem_wdata = DQ_i;
              ovf_d     = 1'b0;
              err_d     = 1'b0;
              state_d   = S_RESP;
            end
            CMD_RSV: begin
              ovf_d   = 1'b0;
              err_d   = 1'b1;
              state_d = S_RESP;
            end
            default: state_d = S_FETCH_A;
          endcase
        end
      end
      S_READ: begin
        dq_d    = mem_q[a_q];
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_FETCH_A: begin
        op_a_d  = mem_q[a_q];
        state_d = S_FETCH_B;
      end
      S_FETCH_B: begin
        op_b_d  = mem_q[b_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        mem_we  = 1'b1;
        dq_d    = alu_res;
        ovf_d   = alu_ovf;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      dq_q    <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      dq_q    <= dq_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Array keeps its contents through reset; writes are gated by state/ready.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_compute_mem_engine.sv
// Bench for compute_mem_engine: three instances (16b wrap, 16b saturating,
// 32b/16-deep) driven in lockstep and checked against an arithmetic model.
module tb_compute_mem_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = '0;
  logic [7:0]  addA = '0;
  logic [7:0]  addB = '0;
  logic [7:0]  addC = '0;
  logic [31:0] d32 = '0;

  logic [2:0]  rdy, rsp, ovf_w, err_w;
  logic [15:0] dq0, dq1;
  logic [31:0] dq2;
  logic [31:0] dqv [3];

  int errors = 0;
  int checks = 0;

  longint mm [3][256];
  longint exp_dq [3];
  bit     exp_ov [3];
  bit     exp_er [3];

  assign dqv[0] = {16'h0, dq0};
  assign dqv[1] = {16'h0, dq1};
  assign dqv[2] = dq2;

  always #5 clk = ~clk;

  compute_mem_engine #(.MEM_WIDTH(16), .ADDR_WIDTH(8), .SAT_EN(0)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
    .cmd(cmd), .addA(addA), .addB(addB), .addC(addC), .DQ_i(d32[15:0]),
    .DQ_o(dq0), .rsp_valid(rsp[0]), .ovf(ovf_w[0]), .err(err_w[0])
  );

  compute_mem_engine #(.MEM_WIDTH(16), .ADDR_WIDTH(8), .SAT_EN(1)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
    .cmd(cmd), .addA(addA), .addB(addB), .addC(addC), .DQ_i(d32[15:0]),
    .DQ_o(dq1), .rsp_valid(rsp[1]), .ovf(ovf_w[1]), .err(err_w[1])
  );

  compute_mem_engine #(.MEM_WIDTH(32), .ADDR_WIDTH(4), .SAT_EN(0)) u2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[2]),
    .cmd(cmd), .addA(addA[3:0]), .addB(addB[3:0]), .addC(addC[3:0]),
    .DQ_i(d32), .DQ_o(dq2), .rsp_valid(rsp[2]), .ovf(ovf_w[2]),
    .err(err_w[2])
  );

  function automatic int wd(input int i);
    return (i == 2) ? 32 : 16;
  endfunction

  function automatic int am(input int i);
    return (i == 2) ? 15 : 255;
  endfunction

  function automatic void alu(input int w, input bit s, input logic [2:0] op,
                              input longint x, input longint y,
                              output longint r, output bit o);
    longint mx;
    mx = (longint'(1) << w) - 1;
    o = 1'b0;
    r = 0;
    case (op)
      3'd2: begin
        r = x + y;
        o = (r > mx);
        if (o) r = s ? mx : r - (mx + 1);
      end
      3'd3: begin
        o = (x < y);
        if (o) r = s ? 0 : x - y + mx + 1;
        else r = x - y;
      end
      3'd4: r = x & y;
      3'd5: r = x | y;
      3'd6: r = x ^ y;
      default: r = 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ex);
    end
  endtask

  task automatic model_step(input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c,
                            input logic [31:0] d, output int lat);
    longint mx, r;
    bit o;
    int ia, ib, ic;
    lat = 4;
    for (int i = 0; i < 3; i++) begin
      mx = (longint'(1) << wd(i)) - 1;
      ia = int'(a) & am(i);
      ib = int'(b) & am(i);
      ic = int'(c) & am(i);
      case (op)
        3'd0: begin
          exp_dq[i] = mm[i][ia];
          exp_ov[i] = 0; exp_er[i] = 0; lat = 2;
        end
        3'd1: begin
          mm[i][ic] = longint'(d) & mx;
          exp_ov[i] = 0; exp_er[i] = 0; lat = 1;
        end
        3'd7: begin
          exp_ov[i] = 0; exp_er[i] = 1; lat = 1;
        end
        default: begin
          alu(wd(i), i == 1, op, mm[i][ia], mm[i][ib], r, o);
          mm[i][ic] = r;
          exp_dq[i] = r;
          exp_ov[i] = o; exp_er[i] = 0; lat = 4;
        end
      endcase
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c,
                        input logic [31:0] d, input bit hold);
    int n, lat, elat;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = op;
    addA = a; addB = b; addC = c; d32 = d;
    n = 0;
    while (!rdy[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", rdy[0], 1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    model_step(op, a, b, c, d, elat);
    lat = 1;
    while (!rsp[0] && lat < 12) begin
      if (hold) chk("busy_ready_low", rdy, 0);
      @(posedge clk); #1;
      lat++;
    end
    cmd_valid = 1'b0;
    chk($sformatf("latency_cmd%0d", op), lat, elat);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rsp_valid%0d", i), rsp[i], 1);
      chk($sformatf("dq%0d_cmd%0d", i, op), dqv[i], exp_dq[i]);
      chk($sformatf("ovf%0d_cmd%0d", i, op), ovf_w[i], exp_ov[i]);
      chk($sformatf("err%0d_cmd%0d", i, op), err_w[i], exp_er[i]);
    end
    @(posedge clk); #1;
    chk("rsp_one_cycle", rsp, 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a, b, c;
    logic [31:0] d;
    bit          cd;
    logic [15:0] e0, e1;
    logic [31:0] e2;
    bit          eo, ee;
  } vec_t;

  vec_t tbl [$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{3'd1, 8'h00, 8'h00, 8'h10, 32'h00001234, 0, 16'h0, 16'h0, 32'h0, 0, 0});
    tbl.push_back('{3'd0, 8'h10, 8'h00, 8'h00, 32'h0, 1, 16'h1234, 16'h1234, 32'h00001234, 0, 0});
    tbl.push_back('{3'd1, 8'h00, 8'h00, 8'h01, 32'h0000FFFF, 0, 16'h0, 16'h0, 32'h0, 0, 0});
    tbl.push_back('{3'd1, 8'h00, 8'h00, 8'h02, 32'h00000002, 0, 16'h0, 16'h0, 32'h0, 0, 0});
    tbl.push_back('{3'd2, 8'h01, 8'h02, 8'h03, 32'h0, 1, 16'h0001, 16'hFFFF, 32'h00010001, 1, 0});
    tbl.push_back('{3'd0, 8'h03, 8'h00, 8'h00, 32'h0, 1, 16'h0001, 16'hFFFF, 32'h00010001, 0, 0});
    tbl.push_back('{3'd1, 8'h00, 8'h00, 8'h04, 32'h00000005, 0, 16'h0, 16'h0, 32'h0, 0, 0});
    tbl.push_back('{3'd1, 8'h00, 8'h00, 8'h05, 32'h00000007, 0, 16'h0, 16'h0, 32'h0, 0, 0});
    tbl.push_back('{3'd3, 8'h04, 8'h05, 8'h04, 32'h0, 1, 16'hFFFE, 16'h0000, 32'hFFFFFFFE, 1, 0});
    tbl.push_back('{3'd0, 8'h04, 8'h00, 8'h00, 32'h0, 1, 16'hFFFE, 16'h0000, 32'hFFFFFFFE, 0, 0});
    tbl.push_back('{3'd7, 8'h04, 8'h05, 8'h04, 32'hDEADBEEF, 1, 16'hFFFE, 16'h0000, 32'hFFFFFFFE, 0, 1});
    tbl.push_back('{3'd0, 8'h04, 8'h00, 8'h00, 32'h0, 1, 16'hFFFE, 16'h0000, 32'hFFFFFFFE, 0, 0});
    tbl.push_back('{3'd1, 8'h00, 8'h00, 8'h06, 32'h0000F0F0, 0, 16'h0, 16'h0, 32'h0, 0, 0});
    tbl.push_back('{3'd1, 8'h00, 8'h00, 8'h07, 32'h00003C3C, 0, 16'h0, 16'h0, 32'h0, 0, 0});
    tbl.push_back('{3'd4, 8'h06, 8'h07, 8'h08, 32'h0, 1, 16'h3030, 16'h3030, 32'h00003030, 0, 0});
    tbl.push_back('{3'd5, 8'h06, 8'h07, 8'h08, 32'h0, 1, 16'hFCFC, 16'hFCFC, 32'h0000FCFC, 0, 0});
    tbl.push_back('{3'd6, 8'h06, 8'h07, 8'h08, 32'h0, 1, 16'hCCCC, 16'hCCCC, 32'h0000CCCC, 0, 0});
    tbl.push_back('{3'd1, 8'h00, 8'h00, 8'h09, 32'hFFFF0000, 0, 16'h0, 16'h0, 32'h0, 0, 0});
    tbl.push_back('{3'd1, 8'h00, 8'h00, 8'h0A, 32'h0F0F0F0F, 0, 16'h0, 16'h0, 32'h0, 0, 0});
    tbl.push_back('{3'd6, 8'h09, 8'h0A, 8'h0F, 32'h0, 1, 16'h0F0F, 16'h0F0F, 32'hF0F00F0F, 0, 0});
    tbl.push_back('{3'd0, 8'h0F, 8'h00, 8'h00, 32'h0, 1, 16'h0F0F, 16'h0F0F, 32'hF0F00F0F, 0, 0});

    #3 rst = 1'b0;
    #1;
    chk("reset_ready", rdy, 0);
    chk("reset_rsp", rsp, 0);
    chk("reset_ovf", ovf_w, 0);
    chk("reset_err", err_w, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_dq%0d", i), dqv[i], 0);
    for (int i = 0; i < 3; i++) begin
      exp_dq[i] = 0; exp_ov[i] = 0; exp_er[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 chk("ready_after_release", rdy, 3'b111);

    for (int k = 0; k < 256; k++)
      do_cmd(3'd1, 8'h0, 8'h0, 8'(k), $urandom, 0);

    foreach (tbl[k]) begin
      do_cmd(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].c, tbl[k].d, 0);
      if (tbl[k].cd) begin
        chk($sformatf("vec%0d_dq0", k), dq0, tbl[k].e0);
        chk($sformatf("vec%0d_dq1", k), dq1, tbl[k].e1);
        chk($sformatf("vec%0d_dq2", k), dq2, tbl[k].e2);
      end
      chk($sformatf("vec%0d_ovf0", k), ovf_w[0], tbl[k].eo);
      chk($sformatf("vec%0d_ovf1", k), ovf_w[1], tbl[k].eo);
      chk($sformatf("vec%0d_err0", k), err_w[0], tbl[k].ee);
    end

    // cmd_valid held through the whole busy period must execute once only
    do_cmd(3'd2, 8'h0B, 8'h0B, 8'h0B, 32'h0, 1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_second_exec", rsp, 0);
    end
    do_cmd(3'd0, 8'h0B, 8'h00, 8'h00, 32'h0, 0);

    // reset in the middle of an ALU op aborts it without a write
    do_cmd(3'd1, 8'h0, 8'h0, 8'h0C, 32'h1234AAAA, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd2;
    addA = 8'h0C; addB = 8'h0C; addC = 8'h0C;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_busy", rdy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_rsp", rsp, 0);
    chk("abort_ovf", ovf_w, 0);
    chk("abort_err", err_w, 0);
    chk("abort_ready", rdy, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_dq%0d", i), dqv[i], 0);
      exp_dq[i] = 0; exp_ov[i] = 0; exp_er[i] = 0;
    end
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", rsp, 0);
    end
    @(negedge clk) rst = 1'b1;
    #1 chk("abort_release_ready", rdy, 3'b111);
    do_cmd(3'd0, 8'h0C, 8'h00, 8'h00, 32'h0, 0);
    chk("abort_mem_kept", dq0, 16'hAAAA);

    repeat (300) begin
      do_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             8'($urandom), $urandom, $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
